// File: rtl/dram_arb_pkg.sv
// Shared definitions for the two-master DRAM arbiter.
//   state_t       : arbiter FSM encoding (IDLE -> BUSY -> DRAIN -> IDLE)
//   M_IFETCH      : master index of the instruction-fetch port (port 0)
//   M_DATA        : master index of the load/store port (port 1)
//   WD_WIDTH      : width of the watchdog counter
package dram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic M_IFETCH = 1'b0;
    localparam logic M_DATA   = 1'b1;

    // The watchdog never counts past TIMEOUT (<= 65535), so 16 bits cannot wrap.
    localparam int WD_WIDTH = 16;

endpackage

// File: rtl/dram_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the DRAM slave.
//   m0_* : instruction-fetch master (req/we/addr/wdata in, rdata/ack back)
//   m1_* : load/store master, same shape as m0_*
//   mem_*: DRAM side (cs/we/addr/wdata out of the arbiter, rdata/ack back)
// Modports:
//   slave  : the arbiter's view -- it serves the masters and drives the DRAM.
//   master : the surrounding system's view (masters plus DRAM model).
interface dram_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_ack;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_ack;

    logic                  mem_cs;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_rdata, m0_ack,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_rdata, m1_ack,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_rdata, m1_ack,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/dram_arbiter_rr_arbiter2.sv
// Combinational two-requester round-robin picker.
//   req[1:0]   : request vector, bit index = master index
//   last_grant : master that won the previous arbitration
//   gnt[1:0]   : one-hot grant, or zero when nobody requests
// A lone requester always wins; on contention the master that did not win
// last time is chosen.
module rr_arbiter2
    import dram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[M_IFETCH] && req[M_DATA]) begin
            if (last_grant == M_DATA) begin
                gnt[M_IFETCH] = 1'b1;
            end else begin
                gnt[M_DATA] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Two-master DRAM arbiter: instruction fetch (port 0) and load/store (port 1)
// share one DRAM slave.  Each access raises mem_cs until the first mem_ack,
// then waits in DRAIN until the slave's ack tail has ended so a lingering
// ack can never be mistaken for the next access.  A watchdog aborts accesses
// that see no ack within TIMEOUT cycles and sets the sticky timeout_err.
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   bus         : dram_arbiter_if.slave (masters m0/m1 and DRAM mem_*)
//   timeout_err : sticky watchdog-abort flag, cleared only by rst
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    dram_arbiter_if.slave        bus,
    output logic                 timeout_err
);

    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT);

    state_t              state_reg, state_next;
    logic                last_grant_reg;
    logic                owner_reg;
    logic [WD_WIDTH-1:0] wd_cnt_reg;

    logic [1:0]          req_vec;
    logic [1:0]          gnt;
    logic                grant_fire;
    logic                ack_fire;
    logic                abort_fire;
    logic                done_fire;
    logic                grant_idx;

    assign req_vec = {bus.m1_req, bus.m0_req};

    rr_arbiter2 u_rr (
        .req        (req_vec),
        .last_grant (last_grant_reg),
        .gnt        (gnt)
    );

    assign grant_idx = gnt[M_DATA] ? M_DATA : M_IFETCH;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and the event strobes used by the datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant_fire = 1'b0;
        ack_fire   = 1'b0;
        abort_fire = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // mem_ack here is a stray and is deliberately ignored.
                if (|gnt) begin
                    grant_fire = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ack) begin
                    ack_fire   = 1'b1;
                    state_next = ST_DRAIN;
                end else if (wd_cnt_reg == WD_LIMIT) begin
                    abort_fire = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.mem_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign done_fire = ack_fire | abort_fire;

    // ------------------------------------------------------------------
    // Datapath: DRAM command, watchdog, master responses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= M_DATA;   // so port 0 wins the first contention
            owner_reg      <= M_IFETCH;
            wd_cnt_reg     <= '0;
            bus.mem_cs     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.m0_rdata   <= '0;
            bus.m1_rdata   <= '0;
            bus.m0_ack     <= 1'b0;
            bus.m1_ack     <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            // Acks are single-cycle pulses by default.
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;

            if (grant_fire) begin
                // Every grant moves the round-robin pointer, so a master that
                // re-requests right after its ack yields to a waiting peer.
                owner_reg      <= grant_idx;
                last_grant_reg <= grant_idx;
                wd_cnt_reg     <= '0;
                bus.mem_cs     <= 1'b1;
                if (grant_idx == M_DATA) begin
                    bus.mem_we    <= bus.m1_we;
                    bus.mem_addr  <= bus.m1_addr;
                    bus.mem_wdata <= bus.m1_wdata;
                end else begin
                    bus.mem_we    <= bus.m0_we;
                    bus.mem_addr  <= bus.m0_addr;
                    bus.mem_wdata <= bus.m0_wdata;
                end
            end

            if (state_reg == ST_BUSY && !done_fire) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end

            if (done_fire) begin
                bus.mem_cs <= 1'b0;
                // An aborted access still acks so the master cannot hang;
                // its rdata is left untouched.
                if (owner_reg == M_DATA) begin
                    bus.m1_ack <= 1'b1;
                    if (ack_fire && !bus.mem_we) begin
                        bus.m1_rdata <= bus.mem_rdata;
                    end
                end else begin
                    bus.m0_ack <= 1'b1;
                    if (ack_fire && !bus.mem_we) begin
                        bus.m0_rdata <= bus.mem_rdata;
                    end
                end
            end

            if (abort_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic timeout_err;

    always #5 clk = ~clk;

    dram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dram_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    // ---------------- bookkeeping ----------------
    int chk_total = 0;
    int chk_pass  = 0;
    int cyc       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_total++;
        if (got === exp) begin
            chk_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- DRAM model ----------------
    logic        stray_ack    = 1'b0;
    logic        dram_mute    = 1'b0;
    int          dram_delay   = 0;
    int          dram_ack_len = 1;
    int          dram_accesses = 0;
    logic [31:0] dram [64];
    logic [1:0]  d_state = 2'd0;
    int          d_cnt   = 0;
    logic        d_ack   = 1'b0;
    logic [31:0] d_rd    = 32'h0;

    function automatic logic [31:0] preload(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 | 32'(i));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state <= 2'd0;
            d_cnt   <= 0;
            d_ack   <= 1'b0;
            d_rd    <= 32'h0;
            for (int i = 0; i < 64; i++) dram[i] <= preload(i);
        end else begin
            case (d_state)
                2'd0: if (bus.mem_cs && !dram_mute) begin
                    dram_accesses <= dram_accesses + 1;
                    d_rd <= dram[bus.mem_addr[7:2]];
                    if (bus.mem_we) dram[bus.mem_addr[7:2]] <= bus.mem_wdata;
                    if (dram_delay == 0) begin
                        d_state <= 2'd2;
                        d_ack   <= 1'b1;
                        d_cnt   <= dram_ack_len - 1;
                    end else begin
                        d_state <= 2'd1;
                        d_cnt   <= dram_delay - 1;
                    end
                end
                2'd1: if (d_cnt == 0) begin
                    d_state <= 2'd2;
                    d_ack   <= 1'b1;
                    d_cnt   <= dram_ack_len - 1;
                end else begin
                    d_cnt <= d_cnt - 1;
                end
                default: if (d_cnt == 0) begin
                    d_state <= 2'd0;
                    d_ack   <= 1'b0;
                end else begin
                    d_cnt <= d_cnt - 1;
                end
            endcase
        end
    end

    // Idle DRAM returns garbage on rdata; it must never be captured.
    assign bus.mem_ack   = d_ack | stray_ack;
    assign bus.mem_rdata = d_ack ? d_rd : 32'hBAD0_BAD0;

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] ref_mem [64];
    logic [31:0] exp_last [2];
    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];
    int          ack_log [$];
    int          ack_cnt      = 0;
    int          both_ack_cnt = 0;
    int          tail_cs_cnt  = 0;

    task automatic init_ref();
        for (int i = 0; i < 64; i++) ref_mem[i] = preload(i);
        exp_last[0] = 32'h0;
        exp_last[1] = 32'h0;
    endtask

    // Monitor: pops the scoreboard on every master ack.
    initial begin
        logic prev_mem_ack;
        logic [31:0] e;
        prev_mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.m0_ack && bus.m1_ack) both_ack_cnt++;
                if (prev_mem_ack && bus.mem_cs) tail_cs_cnt++;
                if (bus.m0_ack) begin
                    ack_cnt++;
                    ack_log.push_back(0);
                    check("m0_ack_expected", 32'(sb0.size() != 0), 32'd1);
                    if (sb0.size() != 0) begin
                        e = sb0.pop_front();
                        check("m0_rdata", bus.m0_rdata, e);
                        $display("txn m0 ack rdata=0x%08h cyc=%0d", bus.m0_rdata, cyc);
                    end
                end
                if (bus.m1_ack) begin
                    ack_cnt++;
                    ack_log.push_back(1);
                    check("m1_ack_expected", 32'(sb1.size() != 0), 32'd1);
                    if (sb1.size() != 0) begin
                        e = sb1.pop_front();
                        check("m1_rdata", bus.m1_rdata, e);
                        $display("txn m1 ack rdata=0x%08h cyc=%0d", bus.m1_rdata, cyc);
                    end
                end
            end
            prev_mem_ack = bus.mem_ack;
        end
    end

    // One master access: pushes the expected rdata, drives the request,
    // waits (bounded) for the ack and returns the grant-to-ack latency.
    task automatic access(input int m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic aborted, output int lat);
        logic [31:0] e;
        int n;
        int g;
        logic seen;
        if (we || aborted) e = exp_last[m];
        else               e = ref_mem[addr[7:2]];
        if (we && !aborted) ref_mem[addr[7:2]] = wdata;
        exp_last[m] = e;
        if (m == 0) begin
            sb0.push_back(e);
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_req = 1'b1;
        end else begin
            sb1.push_back(e);
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_req = 1'b1;
        end
        g = -1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (g < 0 && bus.mem_cs) g = cyc;
            seen = (m == 0) ? bus.m0_ack : bus.m1_ack;
        end
        check("ack_wait", 32'(seen), 32'd1);
        lat = seen ? (cyc - g) : -1;
        if (m == 0) bus.m0_req = 1'b0;
        else        bus.m1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int a0;
        int c0;
        int t0;
        int b0;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        init_ref();

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_mem_cs", 32'(bus.mem_cs), 32'd0);
        check("rst_m0_ack", 32'(bus.m0_ack), 32'd0);
        check("rst_m1_ack", 32'(bus.m1_ack), 32'd0);
        check("rst_m0_rdata", bus.m0_rdata, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Stray ack in IDLE
        a0 = ack_cnt; c0 = dram_accesses;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check("stray_cs", 32'(bus.mem_cs), 32'd0);
        repeat (3) @(negedge clk);
        check("stray_cs_later", 32'(bus.mem_cs), 32'd0);
        check("stray_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("stray_no_access", 32'(dram_accesses - c0), 32'd0);

        // Single read, delay 0, two-cycle ack tail
        dram_delay = 0; dram_ack_len = 2;
        a0 = ack_cnt; c0 = dram_accesses; t0 = tail_cs_cnt;
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, lat);
        check("rd0_latency", 32'(lat), 32'd2);
        repeat (4) @(negedge clk);
        check("rd0_ack_count", 32'(ack_cnt - a0), 32'd1);
        check("rd0_accesses", 32'(dram_accesses - c0), 32'd1);
        check("rd0_cs_in_tail", 32'(tail_cs_cnt - t0), 32'd0);

        // m1 write then read, delay 5
        dram_delay = 5; dram_ack_len = 2;
        a0 = ack_cnt; c0 = dram_accesses; t0 = tail_cs_cnt;
        access(1, 1'b1, 32'h20, 32'h0000CAFE, 1'b0, lat);
        check("wr1_latency", 32'(lat), 32'd7);
        @(negedge clk);
        access(1, 1'b0, 32'h20, 32'h0, 1'b0, lat);
        check("rd1_latency", 32'(lat), 32'd7);
        repeat (4) @(negedge clk);
        check("wr_rd_ack_count", 32'(ack_cnt - a0), 32'd2);
        check("wr_rd_accesses", 32'(dram_accesses - c0), 32'd2);
        check("wr_rd_cs_in_tail", 32'(tail_cs_cnt - t0), 32'd0);
        check("rd1_rdata_held", bus.m1_rdata, 32'h0000CAFE);

        // Contention: both masters keep re-requesting
        dram_delay = 1; dram_ack_len = 2;
        ack_log.delete();
        b0 = both_ack_cnt; t0 = tail_cs_cnt;
        @(negedge clk);
        fork
            begin
                int l0;
                for (int k = 0; k < 3; k++) begin
                    access(0, 1'b0, 32'h40 + 32'(4 * k), 32'h0, 1'b0, l0);
                    @(negedge clk);
                end
            end
            begin
                int l1;
                for (int k = 0; k < 3; k++) begin
                    access(1, 1'b0, 32'h60 + 32'(4 * k), 32'h0, 1'b0, l1);
                    @(negedge clk);
                end
            end
        join
        check("rr_ack_total", 32'(ack_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < ack_log.size()) check("rr_order", 32'(ack_log[i]), 32'(i % 2));
        end
        check("rr_double_ack", 32'(both_ack_cnt - b0), 32'd0);
        check("rr_cs_in_tail", 32'(tail_cs_cnt - t0), 32'd0);

        // Watchdog abort with a silent DRAM
        dram_mute = 1'b1; dram_delay = 1; dram_ack_len = 1;
        check("pre_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        access(0, 1'b0, 32'h50, 32'h0, 1'b1, lat);
        check("timeout_latency", 32'(lat), 32'd9);
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        dram_mute = 1'b0;
        @(negedge clk);
        access(1, 1'b0, 32'h54, 32'h0, 1'b0, lat);
        check("post_timeout_latency", 32'(lat), 32'd3);
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // Asynchronous reset in the middle of BUSY
        dram_delay = 10; dram_ack_len = 1;
        @(negedge clk);
        bus.m0_we = 1'b0; bus.m0_addr = 32'h10; bus.m0_req = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_pre_busy", 32'(bus.mem_cs), 32'd1);
        a0 = ack_cnt;
        #2 rst = 1'b1;
        #1;
        check("arst_mem_cs", 32'(bus.mem_cs), 32'd0);
        check("arst_m0_ack", 32'(bus.m0_ack), 32'd0);
        check("arst_m0_rdata", bus.m0_rdata, 32'd0);
        check("arst_m1_rdata", bus.m1_rdata, 32'd0);
        check("arst_mem_addr", bus.mem_addr, 32'd0);
        check("arst_timeout_err", 32'(timeout_err), 32'd0);
        bus.m0_req = 1'b0;
        sb0.delete();
        sb1.delete();
        init_ref();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("arst_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("arst_idle_cs", 32'(bus.mem_cs), 32'd0);
        dram_delay = 3;
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, lat);
        check("arst_fresh_latency", 32'(lat), 32'd5);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares one DRAM slave (cs/we/addr/wdata, returning rdata/ack) between two masters.
- Port 0 is instruction fetch; port 1 is the data load/store unit.
- Sequences each access: asserts cs, waits for ack, then drains the slave's multi-cycle ack tail before it issues the next access.
- Uses round-robin arbitration and a watchdog on stalled accesses.

Parameters:
- ADDR_WIDTH, 32, address width for both masters and the DRAM.
- DATA_WIDTH, 32, data width.
- TIMEOUT, 1023, cycles allowed in BUSY before the access is aborted. Range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request. Held high until m0_ack.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  ADDR_WIDTH  master 0 byte address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_rdata  out  DATA_WIDTH  master 0 read data, registered.
- m0_ack  out  1  master 0 completion, one-cycle pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as the m0 signals, for master 1.
- mem_cs  out  1  DRAM chip select.
- mem_we  out  1  DRAM write enable.
- mem_addr  out  ADDR_WIDTH  DRAM address.
- mem_wdata  out  DATA_WIDTH  DRAM write data.
- mem_rdata  in  DATA_WIDTH  DRAM read data. May be Z when the DRAM is idle.
- mem_ack  in  1  DRAM ack. High for 1 or 2 consecutive cycles per access.
- timeout_err  out  1  sticky. Set on a watchdog abort.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - All outputs 0: mem_cs, mem_we, mem_addr, mem_wdata, m*_rdata, m*_ack, timeout_err.
  - last_grant=1, so master 0 wins first.
  - wd_cnt=0.
  - Reset during BUSY or DRAIN abandons the access and pulses no ack.
- IDLE:
  - If neither req is high, stay.
  - If exactly one req is high, grant it.
  - If both are high, grant the master that is not last_grant, then update last_grant.
  - On grant, in the same edge: register the granted master's we/addr/wdata onto mem_*, set mem_cs=1, wd_cnt=0, go to BUSY.
- BUSY:
  - mem_cs stays 1; mem_* fields are held stable.
  - If mem_ack=1:
    - mem_cs=0.
    - If the access is a read, capture mem_rdata into the granted master's rdata. A write leaves rdata unchanged.
    - Pulse the granted m*_ack for exactly 1 cycle, on the next cycle.
    - Go to DRAIN.
  - Else if wd_cnt==TIMEOUT:
    - mem_cs=0, timeout_err=1.
    - Pulse the granted m*_ack with rdata unchanged, so the master is never deadlocked.
    - Go to DRAIN.
  - Else wd_cnt+1.
- DRAIN:
  - mem_cs=0.
  - Stay while mem_ack=1. When mem_ack=0, go to IDLE.
  - This guarantees cs is low while the DRAM passes through its idle state, so no access is duplicated.
- Latency: request accepted at edge N, mem_cs high from N. With a DRAM of delay D, the ack arrives at the first mem_ack edge and m*_ack pulses the following cycle.
- Minimum request-to-request turnaround is IDLE→BUSY→DRAIN→IDLE.
- A master may drop req only after its ack. Dropping req earlier while granted is ignored: the access completes and the ack still pulses.
- A master may re-assert req in the cycle after its ack. If the other master is also waiting, the other master wins (round-robin).
- m*_ack is never asserted for both masters in the same cycle.
- mem_ack seen in IDLE (stray) is ignored.
- timeout_err is cleared only by rst.
- wd_cnt is a 16-bit unsigned counter and cannot wrap, because TIMEOUT ≤ 65535.

Decomposition:
- Shared package dram_arb_pkg holds:
  - state encoding: ST_IDLE=0, ST_BUSY=1, ST_DRAIN=2 (2-bit);
  - master index constants M_IFETCH=0, M_DATA=1.
- One natural sub-module: rr_arbiter2, a combinational two-requester round-robin picker. Inputs req[1:0] and last_grant; outputs gnt[1:0], one-hot or zero.
- The FSM, watchdog and datapath registers stay in dram_arbiter.

Test Plan:
- Single read, m0_addr=0x10, DRAM delay 0 preloaded 0xDEADBEEF at word 4 → mem_cs high until ack; m0_ack pulses once; m0_rdata=0xDEADBEEF; mem_cs low during the whole ack tail; DRAM performs exactly one access.
- Write then read on m1: write 0x0000CAFE @0x20, then read @0x20, DRAM delay 5 → two m1_ack pulses; second m1_rdata=0x0000CAFE; mem_cs=0 during DRAIN both times.
- Contention: m0 and m1 both req from reset, each re-requesting immediately after its ack, 6 transactions → grant order 0,1,0,1,0,1; never two acks in one cycle.
- Timeout: TIMEOUT=8, mem_ack tied 0, m0 read → m0_ack pulses 9 cycles after grant; timeout_err=1 and stays 1; next m1 request is still served after mem_ack is released.
- Async reset mid-BUSY: assert rst between clock edges during a delay-10 read → all outputs 0 immediately; no m*_ack; after reset release, a fresh m0 read completes normally.
- Stray ack: pulse mem_ack in IDLE with no req → no state change; mem_cs stays 0; no m*_ack.
